// File: rtl/flappy_pkg.sv
// -----------------------------------------------------------------------------
// flappy_pkg
// Shared definitions for the pipe generator:
//   - status encodings driven by the game controller (ST_IDLE/ST_RUN/ST_OVER)
//   - FSM state type of pipe_gen
//   - bit offsets of the packed pipe word {x_r[15:0], gap_top[15:0]}
//   - number of pipe slots
// No ports (package).
// -----------------------------------------------------------------------------
package flappy_pkg;

  // Game status as seen on pipe_gen.status; 2'b11 is treated like ST_OVER.
  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_OVER = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_FROZEN = 2'd2
  } state_t;

  // Pipe word layout: right edge in the upper half, gap top in the lower half.
  localparam int X_MSB   = 31;
  localparam int X_LSB   = 16;
  localparam int GAP_MSB = 15;
  localparam int GAP_LSB = 0;

  localparam int NUM_PIPES = 3;

endpackage

// File: rtl/lfsr16.sv
// -----------------------------------------------------------------------------
// lfsr16
// Free-running 16-bit Fibonacci LFSR, taps 16,14,13,11 (bits 15,13,12,10),
// shifting left with the feedback bit entering at bit 0.
// Ports:
//   clk  - system clock
//   rst  - synchronous active-high reset, loads SEED
//   q    - current LFSR state
// -----------------------------------------------------------------------------
module lfsr16
  import flappy_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] q
);

  logic [15:0] r_lfsr;
  logic        w_fb;

  assign w_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

  // NOTE: clocked state uses non-blocking (<=) so every register samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) r_lfsr <= SEED;
    else     r_lfsr <= {r_lfsr[14:0], w_fb};
  end

  assign q = r_lfsr;

endmodule

// File: rtl/pipe_gen.sv
// -----------------------------------------------------------------------------
// pipe_gen
// Generates three scrolling pipes for a side-scroller. Each pipe is described
// by its right edge x_r (the display draws x_r-PIPE_W .. x_r-1) and the top
// of its gap. Pipes scroll left by `speed` px on every tick while running and
// respawn 3*SPACING further right with a pseudo-random gap.
// Optional feature macro: PIPE_SPEEDUP_EN -- every 8 passes raise the scroll
// speed by one, saturating at SPEED_MAX. Without it speed is fixed at SPEED0.
// Ports:
//   clk    - system clock
//   rst    - synchronous active-high reset
//   tick   - one-cycle frame-advance strobe
//   status - game state: 00 idle, 01 run, 10/11 over
//   pipe1..pipe3 - {x_r[15:0], gap_top[15:0]} per pipe, registered
//   pass   - one-cycle pulse after a tick in which a pipe crossed BIRD_X
//   speed  - current scroll speed in px/tick
// -----------------------------------------------------------------------------
module pipe_gen
  import flappy_pkg::*;
#(
  parameter int          SCREEN_W  = 640,
  parameter int          PIPE_W    = 52,
  parameter int          SPACING   = 240,
  parameter int          BIRD_X    = 160,
  parameter int          GAP_MIN   = 64,
  parameter int          SPEED0    = 2,
  parameter int          SPEED_MAX = 4,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic [1:0]  status,
  output logic [31:0] pipe1,
  output logic [31:0] pipe2,
  output logic [31:0] pipe3,
  output logic        pass,
  output logic [2:0]  speed
);

  localparam logic [15:0] WRAP      = 16'(3 * SPACING);
  localparam logic [15:0] BIRD      = 16'(BIRD_X);
  localparam logic [15:0] GAP_BASE  = 16'(GAP_MIN);
  localparam logic [15:0] GAP_INIT  = 16'(GAP_MIN + 128);
  // Base speed can never start above the ceiling.
  localparam logic [2:0]  SPD_START = 3'((SPEED0 > SPEED_MAX) ? SPEED_MAX : SPEED0);

  state_t                        r_state;
  state_t                        w_state_next;
  logic [15:0]                   w_lfsr;
  logic [2:0]                    w_speed;
  logic [15:0]                   w_speed16;
  logic                          w_reinit;
  logic                          w_step;
  logic                          w_pass_evt;
  logic                          r_pass;
  logic [NUM_PIPES-1:0]          w_respawn_vec;
  logic [NUM_PIPES-1:0]          w_cross;
  logic [NUM_PIPES-1:0][31:0]    w_pipe_word;

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk (clk),
    .rst (rst),
    .q   (w_lfsr)
  );

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  // NOTE: the default assignment before the case keeps this block free of
  // inferred latches.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (status == ST_RUN) w_state_next = S_RUN;
      S_RUN: begin
        if (status == ST_IDLE)     w_state_next = S_IDLE;
        else if (status[1])        w_state_next = S_FROZEN;  // 10 or 11
      end
      S_FROZEN: begin
        if (status == ST_IDLE)     w_state_next = S_IDLE;
        else if (status == ST_RUN) w_state_next = S_RUN;
      end
      default:                     w_state_next = S_IDLE;
    endcase
  end

  // Being in (or entering) IDLE pins the pipes, speed and pass counter to
  // their start values; this both holds them in IDLE and reinitialises them.
  assign w_reinit = (w_state_next == S_IDLE);
  // A tick is judged by the current state; reinit overrides its effect.
  assign w_step    = (r_state == S_RUN) && tick && !w_reinit;
  assign w_speed16 = {13'd0, w_speed};

  // ---------------------------------------------------------- pipe slots
  for (genvar gi = 0; gi < NUM_PIPES; gi++) begin : g_slot
    localparam logic [15:0]          X_INIT     = 16'(SCREEN_W + PIPE_W + gi * SPACING);
    localparam logic [NUM_PIPES-1:0] LOWER_MASK = NUM_PIPES'((1 << gi) - 1);

    logic [15:0] r_x;
    logic [15:0] r_gap;
    logic [15:0] w_x_next;
    logic [15:0] w_gap_new;
    logic        w_respawn;
    logic        w_hi_byte;

    assign w_respawn         = !(r_x > w_speed16);
    assign w_respawn_vec[gi] = w_respawn;
    // On respawn the wrap distance is added before subtracting speed so the
    // 16-bit arithmetic never goes below zero.
    assign w_x_next  = w_respawn ? (r_x + WRAP) - w_speed16 : r_x - w_speed16;
    // A lower-numbered slot respawning on the same tick already took the low
    // LFSR byte, so this slot takes the high byte.
    assign w_hi_byte = |(w_respawn_vec & LOWER_MASK);
    assign w_gap_new = GAP_BASE + {8'd0, (w_hi_byte ? w_lfsr[15:8] : w_lfsr[7:0])};
    assign w_cross[gi] = (r_x > BIRD) && (w_x_next <= BIRD);

    always_ff @(posedge clk) begin
      if (rst || w_reinit) begin
        r_x   <= X_INIT;
        r_gap <= GAP_INIT;
      end else if (w_step) begin
        r_x <= w_x_next;
        if (w_respawn) r_gap <= w_gap_new;
      end
    end

    assign w_pipe_word[gi][X_MSB:X_LSB]     = r_x;
    assign w_pipe_word[gi][GAP_MSB:GAP_LSB] = r_gap;
  end

  // ----------------------------------------------------------- pass pulse
  assign w_pass_evt = w_step && (|w_cross);

  always_ff @(posedge clk) begin
    if (rst) r_pass <= 1'b0;
    else     r_pass <= w_pass_evt;
  end

  // ---------------------------------------------------------------- speed
`ifdef PIPE_SPEEDUP_EN
  localparam logic [2:0] SPD_MAX = 3'(SPEED_MAX);

  logic [2:0] r_pass_cnt;
  logic [2:0] r_speed;

  always_ff @(posedge clk) begin
    if (rst || w_reinit) begin
      r_pass_cnt <= '0;
      r_speed    <= SPD_START;
    end else if (w_pass_evt) begin
      r_pass_cnt <= r_pass_cnt + 3'd1;
      // Counter wrapping 7->0 marks the eighth pass of the group.
      if (r_pass_cnt == 3'd7 && r_speed < SPD_MAX) r_speed <= r_speed + 3'd1;
    end
  end

  assign w_speed = r_speed;
`else
  assign w_speed = SPD_START;
`endif

  assign pipe1 = w_pipe_word[0];
  assign pipe2 = w_pipe_word[1];
  assign pipe3 = w_pipe_word[2];
  assign pass  = r_pass;
  assign speed = w_speed;

endmodule

// File: tb/tb_pipe_gen.sv
// -----------------------------------------------------------------------------
// tb_pipe_gen
// Directed bench for pipe_gen. Expected values are pushed to a scoreboard
// queue when the stimulus is applied and popped when the DUT output is
// sampled (on the falling edge). A reference LFSR predicts respawn gaps.
// -----------------------------------------------------------------------------
module tb_pipe_gen;

  localparam int GAP_INIT = 64 + 128;

`ifdef PIPE_SPEEDUP_EN
  localparam int EXP_SPD8  = 3;
  localparam int EXP_SPD16 = 4;
  localparam int EXP_SPD24 = 4;
`else
  localparam int EXP_SPD8  = 2;
  localparam int EXP_SPD16 = 2;
  localparam int EXP_SPD24 = 2;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tick = 1'b0;
  logic [1:0]  status = 2'b00;
  logic [31:0] pipe1, pipe2, pipe3;
  logic        pass;
  logic [2:0]  speed;

  always #5 clk = ~clk;

  pipe_gen dut (
    .clk    (clk),
    .rst    (rst),
    .tick   (tick),
    .status (status),
    .pipe1  (pipe1),
    .pipe2  (pipe2),
    .pipe3  (pipe3),
    .pass   (pass),
    .speed  (speed)
  );

  // Reference LFSR: 16-bit Fibonacci, taps 16,14,13,11, seed 0xACE1.
  logic [15:0] m_lfsr;
  always @(posedge clk) begin
    if (rst) m_lfsr <= 16'hACE1;
    else     m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  end

  // ------------------------------------------------------------ scoreboard
  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_fail   = 0;
  int   seen_pass = 0;

  function automatic logic [31:0] pw(input int x, input int g);
    return {16'(x), 16'(g)};
  endfunction

  task automatic push(input string tag, input logic [31:0] e);
    exp_t item;
    item.tag = tag;
    item.exp = e;
    sb_q.push_back(item);
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t item;
    n_checks++;
    if (sb_q.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty observed=%0h expected=none", obs);
    end else begin
      item = sb_q.pop_front();
      assert (obs === item.exp) n_pass++;
      else begin
        n_fail++;
        $error("FAIL %s observed=%0h expected=%0h", item.tag, obs, item.exp);
      end
    end
  endtask

  task automatic push_pipes(input string tag, input logic [31:0] e1,
                            input logic [31:0] e2, input logic [31:0] e3);
    push({tag, "_pipe1"}, e1);
    push({tag, "_pipe2"}, e2);
    push({tag, "_pipe3"}, e3);
  endtask

  task automatic check_pipes();
    check(pipe1);
    check(pipe2);
    check(pipe3);
  endtask

  // Ticks on consecutive cycles; called at a falling edge, returns at the
  // falling edge after the last tick edge with tick low. Pass pulses are
  // counted at every sample point.
  task automatic tick_n(input int n);
    for (int k = 0; k < n; k++) begin
      tick = 1'b1;
      @(negedge clk);
      if (pass === 1'b1) seen_pass++;
    end
    tick = 1'b0;
  endtask

  task automatic run_until_passes(input int target);
    int guard;
    guard = 0;
    while (seen_pass < target && guard < 3000) begin
      tick_n(1);
      guard++;
    end
  endtask

  // --------------------------------------------------------------- stimulus
  initial begin
    logic [15:0] exp_gap;
    logic [15:0] obs_gap;
    int          base;

    // Reset
    rst = 1'b1;
    push_pipes("reset", pw(692, GAP_INIT), pw(932, GAP_INIT), pw(1172, GAP_INIT));
    push("reset_speed", 32'd2);
    push("reset_pass", 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_pipes();
    check(speed);
    check(pass);

    // IDLE hold
    push_pipes("idle_hold", pw(692, GAP_INIT), pw(932, GAP_INIT), pw(1172, GAP_INIT));
    push("idle_no_pass", 32'd0);
    tick_n(50);
    check_pipes();
    check(seen_pass);

    // Scroll to the bird column
    status = 2'b01;
    @(negedge clk);
    push("scroll265_pipe1", pw(162, GAP_INIT));
    push("scroll265_passes", 32'd0);
    tick_n(265);
    check(pipe1);
    check(seen_pass);
    push("pass_pulse", 32'd1);
    push_pipes("scroll266", pw(160, GAP_INIT), pw(400, GAP_INIT), pw(640, GAP_INIT));
    tick_n(1);
    check(pass);
    check_pipes();
    push("pass_one_cycle", 32'd0);
    @(negedge clk);
    check(pass);
    push("scroll276_passes", 32'd1);
    push("scroll276_pipe1", pw(140, GAP_INIT));
    tick_n(10);
    check(seen_pass);
    check(pipe1);

    // Respawn
    push("pre_respawn_pipe1", pw(2, GAP_INIT));
    tick_n(69);
    check(pipe1);
    tick = 1'b1;
    exp_gap = 16'(64) + {8'd0, m_lfsr[7:0]};
    push_pipes("respawn", {16'd720, exp_gap}, pw(240, GAP_INIT), pw(480, GAP_INIT));
    push("respawn_gap_range", 32'd1);
    @(negedge clk);
    tick = 1'b0;
    check_pipes();
    obs_gap = pipe1[15:0];
    check({31'd0, (obs_gap >= 16'd64 && obs_gap <= 16'd319)});

    // Freeze
    status = 2'b10;
    @(negedge clk);
    push_pipes("frozen", {16'd720, exp_gap}, pw(240, GAP_INIT), pw(480, GAP_INIT));
    push("frozen_speed", 32'd2);
    push("frozen_passes", 32'd1);
    tick_n(20);
    check_pipes();
    check(speed);
    check(seen_pass);

    // Reinit through IDLE
    status = 2'b00;
    push_pipes("reinit", pw(692, GAP_INIT), pw(932, GAP_INIT), pw(1172, GAP_INIT));
    push("reinit_speed", 32'd2);
    repeat (2) @(negedge clk);
    check_pipes();
    check(speed);

    // Resume
    status = 2'b01;
    @(negedge clk);
    push("resume_pipe1", pw(690, GAP_INIT));
    tick_n(1);
    check(pipe1);

    // Speed-up groups of eight passes
    base = seen_pass;
    push("passes_8", 32'(base + 8));
    push("speed_after_8", 32'(EXP_SPD8));
    run_until_passes(base + 8);
    check(seen_pass);
    check(speed);
    push("passes_16", 32'(base + 16));
    push("speed_after_16", 32'(EXP_SPD16));
    run_until_passes(base + 16);
    check(seen_pass);
    check(speed);
    push("passes_24", 32'(base + 24));
    push("speed_after_24", 32'(EXP_SPD24));
    run_until_passes(base + 24);
    check(seen_pass);
    check(speed);

    // Reset wins over tick and status mid-scroll
    rst  = 1'b1;
    tick = 1'b1;
    push_pipes("rst_midscroll", pw(692, GAP_INIT), pw(932, GAP_INIT), pw(1172, GAP_INIT));
    push("rst_midscroll_speed", 32'd2);
    push("rst_midscroll_pass", 32'd0);
    @(negedge clk);
    check_pipes();
    check(speed);
    check(pass);
    rst    = 1'b0;
    tick   = 1'b0;
    status = 2'b00;
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
